bitwise_pipe: RTL and testbench

Parametrised, pipelined successor to the fixed 16-bit NAND gate: a WIDTH-bit bitwise logic unit with eight selectable operations, valid/ready handshakes on both sides and full backpressure. It sits between the CPU datapath or test harness and any consumer that may stall. It is the general bitwise primitive from which ALU front ends are built. It also keeps a wrapping count of completed results for bring-up.

---
 rtl/bitwise_pipe_pkg.sv | 18 +
 rtl/bitwise_pipe_op.sv | 29 ++
 rtl/bitwise_pipe.sv | 147 ++++++++++++++
 tb/tb_bitwise_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pipe_pkg.sv
// Op codes and op field width shared by the bitwise pipeline and its
// combinational op unit.
package bitwise_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NAND = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/bitwise_pipe_op.sv
// bitwise_op: purely combinational WIDTH-bit logic function of (a, b, op).
// NOT and PASS act on operand a only; b is ignored for those codes.
module bitwise_op
  import bitwise_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_NAND: result_o = ~(a_i & b_i);
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XOR:  result_o = a_i ^ b_i;
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_NOT:  result_o = ~a_i;
      OP_PASS: result_o = a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_pipe.sv
// Two-stage valid/ready bitwise logic unit with a wrapping result counter.
// Optional zero/negative flags on the result when BITWISE_PIPE_FLAGS_EN is defined.
module bitwise_pipe
  import bitwise_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITWISE_PIPE_FLAGS_EN
  output logic             out_zr,
  output logic             out_ng,
`endif
  output logic [CNT_W-1:0] done_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends combinationally on out_ready only (S1 may advance into
  // an S2 slot that is emptying this cycle); nothing else is combinational.

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_xfer;
  logic             s2_free;
  logic             s1_adv;
  logic             in_xfer;
  logic [WIDTH-1:0] op_result;

  bitwise_op #(
    .WIDTH(WIDTH)
  ) u_op (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (op_result)
  );

  always_comb begin
    out_xfer = s2_valid_q && out_ready;
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s1_adv;
    in_xfer  = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      s1_op_d = op_e'(in_op);
    end
  end

  // S2 data only changes on a load, so it holds while the consumer stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = op_result;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_NAND;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef BITWISE_PIPE_FLAGS_EN
  logic zr_q, zr_d;
  logic ng_q, ng_d;

  always_comb begin
    zr_d = zr_q;
    ng_d = ng_q;
    if (s1_adv) begin
      zr_d = (op_result == '0);
      ng_d = op_result[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      zr_q <= zr_d;
      ng_q <= ng_d;
    end
  end

  assign out_zr = zr_q;
  assign out_ng = ng_q;
`endif

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign done_count = cnt_q;

endmodule

// File: tb/tb_bitwise_pipe.sv
// Bench for bitwise_pipe: queue-based occupancy/latency model checked every
// cycle, plus directed vectors with literal expected results.
module tb_bitwise_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [15:0]  done_count;
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_data2;
  logic [1:0]   done_count2;
`ifdef BITWISE_PIPE_FLAGS_EN
  logic         out_zr, out_ng, out_zr2, out_ng2;
`endif

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bitwise_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
`ifdef BITWISE_PIPE_FLAGS_EN
    .out_zr(out_zr), .out_ng(out_ng),
`endif
    .done_count(done_count)
  );

  bitwise_pipe #(.WIDTH(W), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2),
`ifdef BITWISE_PIPE_FLAGS_EN
    .out_zr(out_zr2), .out_ng(out_ng2),
`endif
    .done_count(done_count2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           t_q[$];
  logic [W-1:0] got_q[$];
  int           cyc = 0;
  int           cnt = 0;
  int           in_cnt = 0;

  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return ~(a & b);
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  // Entries in flight: the oldest is presented once two edges have passed
  // since its acceptance; with two in flight the unit only takes more when
  // the consumer is taking one.
  function automatic logic model_out_valid();
    return (exp_q.size() > 0) && (cyc >= t_q[0] + 2);
  endfunction

  function automatic logic model_in_ready();
    return (exp_q.size() < 2) || out_ready;
  endfunction

  always @(posedge clk) begin : model_upd
    logic ev, ir;
    if (reset) begin
      exp_q.delete();
      t_q.delete();
      got_q.delete();
      cnt = 0;
    end else begin
      ev = model_out_valid();
      ir = model_in_ready();
      if (ev && out_ready) begin
        void'(exp_q.pop_front());
        void'(t_q.pop_front());
        cnt++;
      end
      if (in_valid && ir) begin
        exp_q.push_back(golden(in_a, in_b, in_op));
        t_q.push_back(cyc);
        in_cnt++;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    logic ev;
    if (!reset) begin
      ev = model_out_valid();
      check("in_ready", 32'(in_ready), 32'(model_in_ready()));
      check("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef BITWISE_PIPE_FLAGS_EN
        check("out_zr", 32'(out_zr), 32'(exp_q[0] == '0));
        check("out_ng", 32'(out_ng), 32'(exp_q[0][W-1]));
`endif
      end
      check("done_count", 32'(done_count), 32'(cnt[15:0]));
      check("done_count_w2", 32'(done_count2), 32'(cnt[1:0]));
      check("out_valid_w2", 32'(out_valid2), 32'(ev));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] sweep_exp [8];
  logic [W-1:0] bp_exp [3];
  int base;
  int guard;
  int start;

  initial begin
    sweep_exp = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA};
    bp_exp = '{16'hF33F, 16'h0CC0, 16'h3FF3};

    step(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0000);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BITWISE_PIPE_FLAGS_EN
    check("rst_out_zr", 32'(out_zr), 32'd0);
    check("rst_out_ng", 32'(out_ng), 32'd0);
`endif
    step(1);

    // op sweep, streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'hAAAA, 16'h5555, 3'(i));
    step(4);
    check("sweep_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check($sformatf("sweep_op%0d", i), 32'(got_q[i]), 32'(sweep_exp[i]));
    check("sweep_done_count", 32'(done_count), 32'd8);
    check("sweep_done_count_w2", 32'(done_count2), 32'd0);

    // backpressure
    out_ready = 1'b0;
    base = got_q.size();
    send(16'h3CC3, 16'h0FF0, 3'd0);
    send(16'h3CC3, 16'h0FF0, 3'd1);
    in_valid = 1'b1;
    in_op = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'hF33F);
      step(1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_refill_ready", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
    step(4);
    check("bp_count", 32'(got_q.size() - base), 32'd3);
    for (int i = 0; i < 3 && base + i < got_q.size(); i++)
      check($sformatf("bp_res%0d", i), 32'(got_q[base+i]), 32'(bp_exp[i]));

`ifdef BITWISE_PIPE_FLAGS_EN
    out_ready = 1'b0;
    send(16'hFFFF, 16'hFFFF, 3'd0);
    step(1);
    @(negedge clk);
    check("flag1_data", 32'(out_data), 32'h0000);
    check("flag1_zr", 32'(out_zr), 32'd1);
    check("flag1_ng", 32'(out_ng), 32'd0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    send(16'h0000, 16'h0000, 3'd0);
    step(1);
    @(negedge clk);
    check("flag2_data", 32'(out_data), 32'hFFFF);
    check("flag2_zr", 32'(out_zr), 32'd0);
    check("flag2_ng", 32'(out_ng), 32'd1);
    out_ready = 1'b1;
    step(3);
`endif

    // random streaming
    start = in_cnt;
    guard = 0;
    while (in_cnt - start < 1000 && guard < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_op = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
      guard++;
    end
    check("stream_accepted", 32'(in_cnt - start >= 1000), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(5);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("stream_done_vs_xfers", 32'(done_count), 32'(got_q.size()));

    // reset with two entries in flight
    out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 3'd1);
    send(16'h1234, 16'h00FF, 3'd2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_done_count", 32'(done_count), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    step(1);
    out_ready = 1'b1;
    step(5);
    check("mrst_no_stale", 32'(got_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
